// File: rtl/mudi_unit_pkg.sv
// mudi_unit_pkg: shared op codes and op-class helpers for the multiply/divide unit
package mudi_unit_pkg;
  typedef enum logic [2:0] {
    MUDI_MULT  = 3'b000,
    MUDI_MULTU = 3'b001,
    MUDI_DIV   = 3'b010,
    MUDI_DIVU  = 3'b011,
    MUDI_MTHI  = 3'b100,
    MUDI_MTLO  = 3'b101,
    MUDI_FDIV  = 3'b110,
    MUDI_NOP   = 3'b111
  } mudi_op_e;

  function automatic logic op_is_mul(input logic [2:0] op);
    return op inside {MUDI_MULT, MUDI_MULTU};
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return op inside {MUDI_DIV, MUDI_DIVU, MUDI_FDIV};
  endfunction
endpackage

// File: rtl/mudi_div_core.sv
// mudi_div_core: combinational 32-bit divider with truncating or floor semantics
module mudi_div_core (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sgn,
  input  logic        i_flr,
  output logic [31:0] o_q,
  output logic [31:0] o_r,
  output logic        o_div0
);
  logic        w_neg_a, w_neg_b, w_adj;
  logic [31:0] w_ua, w_ub, w_uq, w_ur, w_tq, w_tr;

  assign o_div0  = i_b == '0;
  assign w_neg_a = i_sgn && i_a[31];
  assign w_neg_b = i_sgn && i_b[31];
  assign w_ua    = w_neg_a ? -i_a : i_a;
  // divisor forced to 1 on zero so the datapath never divides by zero; result is discarded
  assign w_ub    = o_div0 ? 32'd1 : (w_neg_b ? -i_b : i_b);
  assign w_uq    = w_ua / w_ub;
  assign w_ur    = w_ua % w_ub;
  // truncating result: quotient sign from operand signs, remainder follows dividend
  assign w_tq    = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
  assign w_tr    = w_neg_a ? -w_ur : w_ur;
  // floor mode pulls a remainder of the wrong sign over to the divisor's sign
  assign w_adj   = i_flr && (w_tr != '0) && (w_tr[31] != i_b[31]);
  assign o_q     = w_adj ? w_tq - 32'd1 : w_tq;
  assign o_r     = w_adj ? w_tr + i_b : w_tr;
endmodule

// File: rtl/mudi_unit.sv
// mudi_unit: execute-stage multiply/divide unit owning HI/LO with modelled multi-cycle latency
module mudi_unit
  import mudi_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  mudi_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_sel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_busy, w_busy_nxt;
  logic [31:0]   r_hi, r_lo, r_hi_pend, r_lo_pend;
  logic [31:0]   w_hi_nxt, w_lo_nxt, w_hi_pend_nxt, w_lo_pend_nxt;
  logic [31:0]   w_q, w_r;
  logic [63:0]   w_prod;
  logic          w_go, w_commit, w_div0;

  // a start is only accepted while idle; starts during a run are dropped
  assign w_go     = start && (r_cnt == '0);
  assign w_commit = r_cnt == CW'(1);
  assign w_prod   = (mudi_op == MUDI_MULT)
                  ? {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b}
                  : {32'd0, src_a} * {32'd0, src_b};

  mudi_div_core u_div (
    .i_a    (src_a),
    .i_b    (src_b),
    .i_sgn  (mudi_op != MUDI_DIVU),
    .i_flr  (mudi_op == MUDI_FDIV),
    .o_q    (w_q),
    .o_r    (w_r),
    .o_div0 (w_div0)
  );

  // state register: counter, busy flag, committed and pending results
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_hi_pend <= '0;
      r_lo_pend <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_hi_pend <= w_hi_pend_nxt;
      r_lo_pend <= w_lo_pend_nxt;
    end
  end

  // next state: count down while running, load latency on an accepted mult/div
  always_comb begin
    w_cnt_nxt = (r_cnt != '0) ? r_cnt - CW'(1)
              : !w_go ? '0
              : op_is_mul(mudi_op) ? CW'(MULT_CYCLES)
              : op_is_div(mudi_op) ? CW'(DIV_CYCLES)
              : '0;
  end

  // outputs: commit pending on the last run cycle, direct moves in idle, capture pending on start
  always_comb begin
    w_busy_nxt = w_cnt_nxt != '0;
    w_hi_nxt   = w_commit ? r_hi_pend : (w_go && mudi_op == MUDI_MTHI) ? src_a : r_hi;
    w_lo_nxt   = w_commit ? r_lo_pend : (w_go && mudi_op == MUDI_MTLO) ? src_a : r_lo;
    {w_hi_pend_nxt, w_lo_pend_nxt} = !w_go ? {r_hi_pend, r_lo_pend}
                                   : op_is_mul(mudi_op) ? w_prod
                                   : !op_is_div(mudi_op) ? {r_hi_pend, r_lo_pend}
                                   : w_div0 ? {r_hi, r_lo}
                                   : {w_r, w_q};
  end

  assign busy    = r_busy;
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign rd_data = hi_sel ? r_hi : r_lo;
endmodule

// File: tb/tb_mudi_unit.sv
// tb_mudi_unit: table-driven and directed checks of the multiply/divide unit
module tb_mudi_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mudi_op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        hi_sel = 1'b0;
  logic        busy;
  logic [31:0] hi, lo, rd_data;
  int checks = 0;
  int failures = 0;

  mudi_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mudi_op(mudi_op),
    .src_a(src_a), .src_b(src_b), .hi_sel(hi_sel),
    .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, ehi, elo;
    int          cyc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // pulse start for one edge, then count busy cycles (bounded)
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    @(negedge clk);
    start = 1'b1; mudi_op = op; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic move(input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; mudi_op = op; src_a = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  vec_t vecs[13];
  logic [31:0] prev_hi, prev_lo;
  int n;
  logic seen_busy;

  initial begin
    vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'hFFFFFFFC, 10};
    vecs[4]  = '{3'd3, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    vecs[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[6]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[7]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[8]  = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFC, 10};
    vecs[9]  = '{3'd0, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000000, 32'h0000000C, 5};
    vecs[10] = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
    vecs[11] = '{3'd3, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[12] = '{3'd2, 32'h80000000, 32'd2,        32'h00000000, 32'hC0000000, 10};

    // reset state
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_rd", rd_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // table of arithmetic vectors
    for (int i = 0; i < 13; i++) begin
      prev_hi = hi; prev_lo = lo;
      @(negedge clk);
      start = 1'b1; mudi_op = vecs[i].op; src_a = vecs[i].a; src_b = vecs[i].b;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("v%0d_busy_rise", i), {31'd0, busy}, 32'd1);
      chk($sformatf("v%0d_hi_hidden", i), hi, prev_hi);
      n = 0;
      while (busy && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk($sformatf("v%0d_cycles", i), n, vecs[i].cyc);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].ehi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].elo);
      hi_sel = 1'b1; #1;
      chk($sformatf("v%0d_rd_hi", i), rd_data, vecs[i].ehi);
      hi_sel = 1'b0; #1;
      chk($sformatf("v%0d_rd_lo", i), rd_data, vecs[i].elo);
    end

    // divide by zero keeps HI/LO
    move(3'd4, 32'h11);
    move(3'd5, 32'h22);
    run_op(3'd2, 32'd5, 32'd0, n);
    chk("div0_cycles", n, 10);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    // mthi then mtlo back to back; busy never rises
    @(negedge clk);
    start = 1'b1; mudi_op = 3'd4; src_a = 32'hABCD;
    @(negedge clk);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_lo_kept", lo, 32'h22);
    mudi_op = 3'd5; src_a = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    chk("mv_hi", hi, 32'hABCD);
    chk("mv_lo", lo, 32'h1234);
    hi_sel = 1'b1; #1;
    chk("mv_rd_hi", rd_data, 32'hABCD);
    hi_sel = 1'b0; #1;
    chk("mv_rd_lo", rd_data, 32'h1234);

    // op 111 is a no-op
    run_op(3'd7, 32'h5555, 32'h6666, n);
    chk("nop_cycles", n, 0);
    chk("nop_hi", hi, 32'hABCD);
    chk("nop_lo", lo, 32'h1234);

    // start while busy is ignored
    @(negedge clk);
    start = 1'b1; mudi_op = 3'd0; src_a = 32'd3; src_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    @(negedge clk);
    n++;
    start = 1'b1; mudi_op = 3'd3; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n++;
    while (busy && n < 100) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("ign_cycles", n, 5);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd15);
    repeat (12) @(negedge clk);
    chk("ign_no_late_busy", {31'd0, busy}, 32'd0);
    chk("ign_lo_late", lo, 32'd15);

    // asynchronous reset in the middle of a divide
    move(3'd4, 32'h55);
    @(negedge clk);
    start = 1'b1; mudi_op = 3'd3; src_a = 32'd9; src_b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pre_busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen_busy = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    chk("rst_no_busy", {31'd0, seen_busy}, 32'd0);
    chk("rst_hi_late", hi, 32'd0);
    chk("rst_lo_late", lo, 32'd0);

    // unit still works after abort
    run_op(3'd1, 32'd6, 32'd7, n);
    chk("post_cycles", n, 5);
    chk("post_lo", lo, 32'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
